// File: rtl/fifo_bus_arbiter_pkg.sv
// Shared types and constants for the per-output-port bus arbiters of the 4x4 switch.
package fifo_bus_arbiter_pkg;
  localparam int NUM_PORTS   = 4;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot (or zero) grant vector.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/fifo_bus_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first requester after last_ptr wins.
module rr_pick4
  import fifo_bus_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last_ptr,
  output logic [NUM_PORTS-1:0] grant
);
  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = last_ptr + 2'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_bus_arbiter.sv
// Per-output-FIFO responder: round-robin grants one decoder per frame and muxes its words in.
// Optional idle-timeout release is compiled in with `define ARB_TIMEOUT_EN.
module fifo_bus_arbiter
  import fifo_bus_arbiter_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          bus_sel_req,
  input  logic [NUM_PORTS*DATA_W-1:0]   fd_data,
  input  logic [NUM_PORTS-1:0]          fd_valid,
  input  logic [NUM_PORTS-1:0]          fd_eof,
  input  logic                          fifo_afull,
  output logic [NUM_PORTS-1:0]          bus_grant,
  output logic                          bus_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_W-1:0]             fifo_wr_data,
  output logic [FRAME_CNT_W-1:0]        frame_cnt,
  output logic                          timeout_err
);
  arb_state_e             state_q, state_d;
  logic [1:0]             last_ptr_q, last_ptr_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_PORTS-1:0]   rr_grant;
  logic [1:0]             g;
  logic                   accept;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  rr_pick4 u_pick (
    .req      (bus_sel_req),
    .last_ptr (last_ptr_q),
    .grant    (rr_grant)
  );

  assign g         = onehot_to_idx(grant_q);
  assign bus_ready = (state_q == XFER) && !fifo_afull;
  assign accept    = bus_ready && fd_valid[g];

  always_comb begin
    state_d     = state_q;
    last_ptr_d  = last_ptr_q;
    grant_d     = grant_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    frame_cnt_d = frame_cnt_q;
    timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_sel_req != '0 && !fifo_afull) begin
          grant_d = rr_grant;
          state_d = XFER;
`ifdef ARB_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
      end
      XFER: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = fd_data[g*DATA_W +: DATA_W];
`ifdef ARB_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if (fd_eof[g]) begin
            state_d     = RELEASE;
            grant_d     = '0;
            last_ptr_d  = g;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Back-pressured cycles are the FIFO's fault, not the decoder's.
        else if (!fifo_afull) begin
          if (idle_cnt_q == TO_LAST) begin
            state_d    = RELEASE;
            grant_d    = '0;
            last_ptr_d = g;
            timeout_d  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_ptr_q  <= 2'd3;
      grant_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      grant_q     <= grant_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign bus_grant    = grant_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign frame_cnt    = frame_cnt_q;
  assign timeout_err  = timeout_q;
endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Directed self-checking bench for fifo_bus_arbiter; inputs driven and outputs checked on negedge.
module tb_fifo_bus_arbiter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        bus_sel_req;
  logic [4*DATA_W-1:0] fd_data;
  logic [3:0]        fd_valid;
  logic [3:0]        fd_eof;
  logic              fifo_afull;
  logic [3:0]        bus_grant;
  logic              bus_ready;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic [15:0]       frame_cnt;
  logic              timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  fifo_bus_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bus_sel_req(bus_sel_req), .fd_data(fd_data),
    .fd_valid(fd_valid), .fd_eof(fd_eof), .fifo_afull(fifo_afull),
    .bus_grant(bus_grant), .bus_ready(bus_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_sel_req = '0; fd_data = '0; fd_valid = '0; fd_eof = '0; fifo_afull = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus_grant !== 4'b0) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", bus_grant); end
    tests_run++; if (bus_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", bus_ready); end
    tests_run++; if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wr: got en=%b data=%h want 0/00", fifo_wr_en, fifo_wr_data); end
    tests_run++; if (frame_cnt !== 16'd0 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cnt: got cnt=%0d to=%b want 0/0", frame_cnt, timeout_err); end
  endtask

  task automatic test_single_frame();
    logic [7:0] words [3];
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    do_reset();
    bus_sel_req = 4'b0001;
    cyc();
    tests_run++; if (bus_grant !== 4'b0001) begin tests_failed++; $display("FAIL sf_grant: got %b want 0001", bus_grant); end
    tests_run++; if (bus_ready !== 1'b1) begin tests_failed++; $display("FAIL sf_ready: got %b want 1", bus_ready); end
    for (int i = 0; i < 3; i++) begin
      fd_valid = 4'b0001;
      fd_data  = {24'h0, words[i]};
      fd_eof   = (i == 2) ? 4'b0001 : 4'b0000;
      cyc();
      tests_run++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== words[i]) begin tests_failed++; $display("FAIL sf_write%0d: got en=%b data=%h want 1/%h", i, fifo_wr_en, fifo_wr_data, words[i]); end
    end
    tests_run++; if (frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL sf_frame_cnt: got %0d want 1", frame_cnt); end
    tests_run++; if (bus_grant !== 4'b0000 || bus_ready !== 1'b0) begin tests_failed++; $display("FAIL sf_release: got grant=%b ready=%b want 0000/0", bus_grant, bus_ready); end
    idle_inputs();
    cyc();
    tests_run++; if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL sf_no_extra_write: got %b want 0", fifo_wr_en); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    bus_sel_req = 4'b1111;
    fd_valid    = 4'b1111;
    fd_eof      = 4'b1111;
    fd_data     = 32'hD3D2D1D0;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'hD0 + 8'(k % 4);
      cyc();
      tests_run++; if (bus_grant !== exp_g) begin tests_failed++; $display("FAIL rr_grant%0d: got %b want %b", k, bus_grant, exp_g); end
      cyc();
      tests_run++; if (bus_grant !== 4'b0 || fifo_wr_en !== 1'b1 || fifo_wr_data !== exp_d) begin tests_failed++; $display("FAIL rr_release%0d: got grant=%b en=%b data=%h want 0000/1/%h", k, bus_grant, fifo_wr_en, fifo_wr_data, exp_d); end
      cyc();
      tests_run++; if (bus_grant !== 4'b0 || fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL rr_gap%0d: got grant=%b en=%b want 0000/0", k, bus_grant, fifo_wr_en); end
    end
    tests_run++; if (frame_cnt !== 16'd5) begin tests_failed++; $display("FAIL rr_frame_cnt: got %0d want 5", frame_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_sel_req = 4'b0100;
    cyc();
    tests_run++; if (bus_grant !== 4'b0100) begin tests_failed++; $display("FAIL bp_grant: got %b want 0100", bus_grant); end
    fd_valid = 4'b0100; fd_data = 32'h00B00000;
    cyc();
    tests_run++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hB0) begin tests_failed++; $display("FAIL bp_word0: got en=%b data=%h want 1/b0", fifo_wr_en, fifo_wr_data); end
    fifo_afull = 1'b1; fd_data = 32'h00B10000;
    #1;
    tests_run++; if (bus_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_drop: got %b want 0", bus_ready); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      tests_run++; if (bus_ready !== 1'b0 || fifo_wr_en !== 1'b0 || bus_grant !== 4'b0100) begin tests_failed++; $display("FAIL bp_stall%0d: got ready=%b en=%b grant=%b want 0/0/0100", i, bus_ready, fifo_wr_en, bus_grant); end
    end
    fifo_afull = 1'b0;
    cyc();
    tests_run++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hB1) begin tests_failed++; $display("FAIL bp_word1: got en=%b data=%h want 1/b1", fifo_wr_en, fifo_wr_data); end
    fd_data = 32'h00B20000; fd_eof = 4'b0100;
    cyc();
    tests_run++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hB2 || frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL bp_word2: got en=%b data=%h cnt=%0d want 1/b2/1", fifo_wr_en, fifo_wr_data, frame_cnt); end
    idle_inputs();
  endtask

  task automatic test_afull_idle();
    do_reset();
    fifo_afull = 1'b1; bus_sel_req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests_run++; if (bus_grant !== 4'b0000) begin tests_failed++; $display("FAIL ai_hold%0d: got %b want 0000", i, bus_grant); end
    end
    fifo_afull = 1'b0;
    cyc();
    tests_run++; if (bus_grant !== 4'b0100) begin tests_failed++; $display("FAIL ai_grant: got %b want 0100", bus_grant); end
    idle_inputs();
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    bus_sel_req = 4'b0010;
    cyc();
    tests_run++; if (bus_grant !== 4'b0010) begin tests_failed++; $display("FAIL mr_grant: got %b want 0010", bus_grant); end
    fd_valid = 4'b0010; fd_data = 32'h0000C000;
    cyc();
    tests_run++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hC0) begin tests_failed++; $display("FAIL mr_word0: got en=%b data=%h want 1/c0", fifo_wr_en, fifo_wr_data); end
    fd_data = 32'h0000C100; fd_eof = 4'b0010; rst = 1'b1;
    cyc();
    tests_run++; if (bus_grant !== 4'b0 || bus_ready !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_wr_data !== 8'h00) begin tests_failed++; $display("FAIL mr_outputs: got grant=%b ready=%b en=%b data=%h want 0000/0/0/00", bus_grant, bus_ready, fifo_wr_en, fifo_wr_data); end
    tests_run++; if (frame_cnt !== 16'd0 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL mr_cnt: got cnt=%0d to=%b want 0/0", frame_cnt, timeout_err); end
    rst = 1'b0; idle_inputs(); bus_sel_req = 4'b0011;
    cyc();
    tests_run++; if (bus_grant !== 4'b0001) begin tests_failed++; $display("FAIL mr_regrant: got %b want 0001", bus_grant); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    bus_sel_req = 4'b1000;
    cyc();
    tests_run++; if (bus_grant !== 4'b1000) begin tests_failed++; $display("FAIL to_grant: got %b want 1000", bus_grant); end
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests_run++; if (bus_grant !== 4'b1000 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_wait%0d: got grant=%b to=%b want 1000/0", i, bus_grant, timeout_err); end
    end
    cyc();
    tests_run++; if (timeout_err !== 1'b1 || bus_grant !== 4'b0000 || frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL to_fire: got to=%b grant=%b cnt=%0d want 1/0000/0", timeout_err, bus_grant, frame_cnt); end
    bus_sel_req = 4'b1001;
    cyc();
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_pulse: got %b want 0", timeout_err); end
    cyc();
    tests_run++; if (bus_grant !== 4'b0001) begin tests_failed++; $display("FAIL to_regrant: got %b want 0001", bus_grant); end
`else
    for (int i = 0; i < 8; i++) begin
      cyc();
      tests_run++; if (bus_grant !== 4'b1000 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_hold%0d: got grant=%b to=%b want 1000/0", i, bus_grant, timeout_err); end
    end
`endif
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_afull_idle();
    test_mid_frame_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
